eth_pkt_gen: RTL and testbench

Ethernet test-packet generator for the e40 end-to-end sample: transmit-side counterpart of the packet monitor. On a start pulse it sources a configured number of frames, or frames continuously, on a 256-bit Avalon-ST source. Each frame carries a programmed MAC dst/src address, a length field and an incrementing payload. Frame layout and beat packing are exactly those the packet monitor checks, so a loopback of generator to monitor reports no dst/src/length errors.

---
 rtl/eth_pkt_pkg.sv | 35 +++
 rtl/eth_pkt_beat_fmt.sv | 48 ++++
 rtl/eth_pkt_gen.sv | 182 ++++++++++++++++++
 tb/tb_eth_pkt_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared definitions for the e40 Ethernet test-packet generator and monitor.
// Frame layout, length limits and generator FSM encoding.
package eth_pkt_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int MIN_LEN       = 46;
  localparam int MAX_LEN       = 1500;
  localparam int BEAT_BYTES    = 32;

  localparam int DST_HI = 255;
  localparam int DST_LO = 208;
  localparam int SRC_HI = 207;
  localparam int SRC_LO = 160;
  localparam int LEN_HI = 159;
  localparam int LEN_LO = 144;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOP,
    ST_DATA
  } gen_state_e;

  function automatic logic [10:0] clamp_len(input logic [10:0] len);
    if (len < 11'(MIN_LEN)) return 11'(MIN_LEN);
    if (len > 11'(MAX_LEN)) return 11'(MAX_LEN);
    return len;
  endfunction

  function automatic logic [5:0] beat_count(input logic [10:0] len);
    logic [11:0] tot;
    tot = 12'(ETH_HDR_BYTES) + {1'b0, len};
    return 6'((tot + 12'd31) >> 5);
  endfunction

endpackage

// File: rtl/eth_pkt_beat_fmt.sv
// Combinational beat formatter: builds one 32-byte beat of a test frame
// from the beat index, payload length and MAC addresses.
module eth_pkt_beat_fmt
  import eth_pkt_pkg::*;
(
  input  logic [5:0]   beat,
  input  logic [10:0]  len,
  input  logic [47:0]  dst,
  input  logic [47:0]  src,
  output logic [255:0] data,
  output logic         eop,
  output logic [4:0]   empty
);

  logic [11:0]  frame_bytes;
  logic [11:0]  neg_bytes;
  logic [5:0]   last_beat;
  logic [111:0] hdr;

  assign frame_bytes = 12'(ETH_HDR_BYTES) + {1'b0, len};
  assign neg_bytes   = 12'd0 - frame_bytes;
  assign last_beat   = beat_count(len) - 6'd1;
  assign hdr         = {dst, src, 5'b0, len};

  assign eop   = (beat == last_beat);
  assign empty = eop ? neg_bytes[4:0] : 5'd0;

  // Byte f of the frame: header, then payload byte k = f-14, then zero fill.
  always_comb begin
    logic [11:0] f;
    logic [3:0]  hi;
    logic [7:0]  byte_v;
    data = '0;
    for (int p = 0; p < BEAT_BYTES; p++) begin
      f  = {1'b0, beat, 5'd0} + 12'(p);
      hi = 4'd13 - f[3:0];
      if (f < 12'(ETH_HDR_BYTES)) begin
        byte_v = hdr[{hi, 3'b0} +: 8];
      end else if (f < frame_bytes) begin
        byte_v = 8'(f - 12'(ETH_HDR_BYTES));
      end else begin
        byte_v = 8'd0;
      end
      data[8*(31-p) +: 8] = byte_v;
    end
  end

endmodule

// File: rtl/eth_pkt_gen.sv
// Ethernet test-packet generator: sources configured frames on a
// 256-bit Avalon-ST source with registered outputs.
module eth_pkt_gen
  import eth_pkt_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_start_gen,
  input  logic         cfg_stop_gen,
  input  logic [47:0]  cfg_dst_addr,
  input  logic [47:0]  cfg_src_addr,
  input  logic [10:0]  cfg_pkt_length,
  input  logic [31:0]  cfg_pkt_number,
  input  logic         cfg_continuous,
  output logic         stat_gen_compl,
  output logic [31:0]  stat_pkt_cnt,
  output logic [255:0] tx_data,
  output logic         tx_valid,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [4:0]   tx_empty,
  output logic [5:0]   tx_error,
  input  logic         tx_ready
);

  gen_state_e state_q, state_d;

  logic [47:0]  dst_q, dst_d;
  logic [47:0]  src_q, src_d;
  logic [10:0]  len_q, len_d;
  logic         cont_q, cont_d;
  logic [31:0]  remain_q, remain_d;
  logic         stop_q, stop_d;
  logic [5:0]   beat_q, beat_d;
  logic [31:0]  cnt_d;
  logic         compl_d;
  logic [255:0] data_d;
  logic         valid_d;
  logic         sop_d;
  logic         eop_d;
  logic [4:0]   empty_d;
  logic         load;

  logic         idle;
  logic [5:0]   fmt_idx;
  logic [10:0]  fmt_len;
  logic [47:0]  fmt_dst;
  logic [47:0]  fmt_src;
  logic [255:0] fmt_data;
  logic         fmt_eop;
  logic [4:0]   fmt_empty;

  assign tx_error = '0;

  // The formatter always prepares the beat that follows the one on the bus.
  assign idle    = (state_q == ST_IDLE);
  assign fmt_idx = (!idle && !tx_eop) ? beat_q + 6'd1 : 6'd0;
  assign fmt_len = idle ? clamp_len(cfg_pkt_length) : len_q;
  assign fmt_dst = idle ? cfg_dst_addr : dst_q;
  assign fmt_src = idle ? cfg_src_addr : src_q;

  eth_pkt_beat_fmt u_fmt (
    .beat  (fmt_idx),
    .len   (fmt_len),
    .dst   (fmt_dst),
    .src   (fmt_src),
    .data  (fmt_data),
    .eop   (fmt_eop),
    .empty (fmt_empty)
  );

  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    src_d    = src_q;
    len_d    = len_q;
    cont_d   = cont_q;
    remain_d = remain_q;
    stop_d   = stop_q | cfg_stop_gen;
    beat_d   = beat_q;
    cnt_d    = stat_pkt_cnt;
    compl_d  = stat_gen_compl;
    data_d   = tx_data;
    valid_d  = tx_valid;
    sop_d    = tx_sop;
    eop_d    = tx_eop;
    empty_d  = tx_empty;
    load     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        compl_d = 1'b1;
        stop_d  = 1'b0;
        if (cfg_start_gen && !cfg_stop_gen) begin
          dst_d    = cfg_dst_addr;
          src_d    = cfg_src_addr;
          len_d    = clamp_len(cfg_pkt_length);
          cont_d   = cfg_continuous;
          remain_d = cfg_pkt_number;
          cnt_d    = '0;
          compl_d  = 1'b0;
          if (cfg_pkt_number != 32'd0 || cfg_continuous) begin
            state_d = ST_SOP;
            load    = 1'b1;
          end
        end
      end
      ST_SOP, ST_DATA: begin
        if (tx_ready) begin
          if (tx_eop) begin
            cnt_d    = stat_pkt_cnt + 32'd1;
            remain_d = remain_q - 32'd1;
            if (stop_q || cfg_stop_gen ||
                (!cont_q && remain_q == 32'd1)) begin
              state_d = ST_IDLE;
              stop_d  = 1'b0;
              compl_d = 1'b1;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              data_d  = '0;
              empty_d = '0;
            end else begin
              state_d = ST_SOP;
              load    = 1'b1;
            end
          end else begin
            state_d = ST_DATA;
            load    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      valid_d = 1'b1;
      sop_d   = (fmt_idx == 6'd0);
      eop_d   = fmt_eop;
      data_d  = fmt_data;
      empty_d = fmt_empty;
      beat_d  = fmt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      dst_q          <= '0;
      src_q          <= '0;
      len_q          <= 11'(MIN_LEN);
      cont_q         <= 1'b0;
      remain_q       <= '0;
      stop_q         <= 1'b0;
      beat_q         <= '0;
      stat_pkt_cnt   <= '0;
      stat_gen_compl <= 1'b1;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      tx_sop         <= 1'b0;
      tx_eop         <= 1'b0;
      tx_empty       <= '0;
    end else begin
      state_q        <= state_d;
      dst_q          <= dst_d;
      src_q          <= src_d;
      len_q          <= len_d;
      cont_q         <= cont_d;
      remain_q       <= remain_d;
      stop_q         <= stop_d;
      beat_q         <= beat_d;
      stat_pkt_cnt   <= cnt_d;
      stat_gen_compl <= compl_d;
      tx_data        <= data_d;
      tx_valid       <= valid_d;
      tx_sop         <= sop_d;
      tx_eop         <= eop_d;
      tx_empty       <= empty_d;
    end
  end

endmodule

// File: tb/tb_eth_pkt_gen.sv
// Testbench for eth_pkt_gen: frame-level reference model with a
// per-cycle beat checker and randomized sink backpressure.
module tb_eth_pkt_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cfg_start_gen = 1'b0;
  logic         cfg_stop_gen = 1'b0;
  logic [47:0]  cfg_dst_addr = '0;
  logic [47:0]  cfg_src_addr = '0;
  logic [10:0]  cfg_pkt_length = '0;
  logic [31:0]  cfg_pkt_number = '0;
  logic         cfg_continuous = 1'b0;
  logic         stat_gen_compl;
  logic [31:0]  stat_pkt_cnt;
  logic [255:0] tx_data;
  logic         tx_valid;
  logic         tx_sop;
  logic         tx_eop;
  logic [4:0]   tx_empty;
  logic [5:0]   tx_error;
  logic         tx_ready = 1'b1;

  eth_pkt_gen dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start_gen  (cfg_start_gen),
    .cfg_stop_gen   (cfg_stop_gen),
    .cfg_dst_addr   (cfg_dst_addr),
    .cfg_src_addr   (cfg_src_addr),
    .cfg_pkt_length (cfg_pkt_length),
    .cfg_pkt_number (cfg_pkt_number),
    .cfg_continuous (cfg_continuous),
    .stat_gen_compl (stat_gen_compl),
    .stat_pkt_cnt   (stat_pkt_cnt),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_sop         (tx_sop),
    .tx_eop         (tx_eop),
    .tx_empty       (tx_empty),
    .tx_error       (tx_error),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] data;
    logic         sop;
    logic         eop;
    logic [4:0]   empty;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          m_left = 0;
  int          m_cnt = 0;
  int          m_len = 46;
  bit          m_cont = 0;
  bit          m_stop = 0;
  logic [47:0] m_dst = '0;
  logic [47:0] m_src = '0;
  bit          rand_ready = 0;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Lay the whole frame out as a byte array, then cut it into beats.
  function automatic void push_frame();
    byte unsigned fr[];
    int           n;
    int           nb;
    beat_t        bt;
    n  = 14 + m_len;
    nb = (n + 31) / 32;
    fr = new[nb * 32];
    foreach (fr[i]) fr[i] = 8'd0;
    for (int i = 0; i < 6; i++) begin
      fr[i]     = m_dst[8*(5-i) +: 8];
      fr[6 + i] = m_src[8*(5-i) +: 8];
    end
    fr[12] = 8'(m_len >> 8);
    fr[13] = 8'(m_len & 255);
    for (int k = 0; k < m_len; k++) fr[14 + k] = 8'(k & 255);
    for (int b = 0; b < nb; b++) begin
      bt.data = '0;
      for (int p = 0; p < 32; p++) bt.data[8*(31-p) +: 8] = fr[32*b + p];
      bt.sop   = (b == 0);
      bt.eop   = (b == nb - 1);
      bt.empty = bt.eop ? 5'(nb * 32 - n) : 5'd0;
      exp_q.push_back(bt);
    end
  endfunction

  // Beat checker and sink: the head of the queue must be on the bus
  // every valid cycle, and only leaves on an accepted transfer.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_valid) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got sop=%0b eop=%0b want none",
                     tx_sop, tx_eop);
          end else begin
            e = exp_q[0];
            check("beat_data", tx_data, e.data);
            check("beat_ctrl", {tx_sop, tx_eop, tx_empty, tx_error},
                  {e.sop, e.eop, e.empty, 6'd0});
          end
        end
        tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (tx_valid && tx_ready && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.eop) begin
            m_cnt++;
            m_left--;
            if (m_stop || (!m_cont && m_left == 0)) m_stop = 0;
            else push_frame();
          end
        end
      end
    end
  end

  task automatic start_gen(input logic [47:0] dst, input logic [47:0] src,
                           input int len, input int num, input bit cont);
    @(negedge clk);
    cfg_dst_addr   = dst;
    cfg_src_addr   = src;
    cfg_pkt_length = 11'(len);
    cfg_pkt_number = 32'(num);
    cfg_continuous = cont;
    cfg_start_gen  = 1'b1;
    m_dst  = dst;
    m_src  = src;
    m_len  = (len < 46) ? 46 : (len > 1500) ? 1500 : len;
    m_cont = cont;
    m_left = num;
    m_cnt  = 0;
    m_stop = 0;
    if (num > 0 || cont) push_frame();
    @(negedge clk);
    cfg_start_gen = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (!(stat_gen_compl && !tx_valid) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy after %0d cycles want idle", n);
    end
    check("pkt_cnt_model", stat_pkt_cnt, m_cnt);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int n;
    repeat (3) @(negedge clk);
    check("reset_state",
          {tx_valid, tx_sop, tx_eop, tx_empty, tx_error, stat_gen_compl,
           stat_pkt_cnt},
          {1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 32'd0});
    check("reset_data", tx_data, '0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {tx_valid, stat_gen_compl}, 2'b01);
    end

    // Minimum frame, single packet, literal expectations.
    start_gen(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 46, 1, 0);
    check("sop_latency", {tx_valid, tx_sop, stat_gen_compl}, 3'b110);
    check("sop_dst", tx_data[255:208], 48'h0011_2233_4455);
    check("sop_src", tx_data[207:160], 48'hAABB_CCDD_EEFF);
    check("sop_len", tx_data[159:144], 16'h002E);
    check("sop_pay0", tx_data[143:136], 8'h00);
    @(negedge clk);
    check("eop_min", {tx_valid, tx_eop, tx_empty}, {1'b1, 1'b1, 5'd4});
    @(negedge clk);
    check("compl_after_eop", {tx_valid, stat_gen_compl}, 2'b01);
    check("cnt_one", stat_pkt_cnt, 32'd1);

    // Maximum frames at full rate, with an ignored start mid-run.
    start_gen(48'h0102_0304_0506, 48'h1112_1314_1516, 1500, 3, 0);
    nvalid = 0;
    while (tx_valid && nvalid < 1000) begin
      nvalid++;
      if (nvalid == 50) begin
        cfg_pkt_length = 11'd46;
        cfg_pkt_number = 32'd1;
        cfg_start_gen  = 1'b1;
      end else begin
        cfg_start_gen = 1'b0;
      end
      @(negedge clk);
    end
    cfg_start_gen = 1'b0;
    check("max_beats", nvalid, 144);
    check("max_cnt", stat_pkt_cnt, 32'd3);
    check("max_compl", stat_gen_compl, 1'b1);
    check("max_drained", exp_q.size(), 0);

    // Backpressure, L=100.
    rand_ready = 1;
    start_gen(48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002, 100, 2, 0);
    wait_idle(2000);
    check("bp_cnt", stat_pkt_cnt, 32'd2);
    rand_ready = 0;
    @(negedge clk);

    // Continuous with a stop issued on an SOP beat.
    start_gen(48'h0000_0000_00AA, 48'h0000_0000_00BB, 64, 5, 1);
    repeat (7) @(negedge clk);
    n = 0;
    while (!(tx_valid && tx_sop) && n < 100) begin
      @(negedge clk);
      n++;
    end
    cfg_stop_gen = 1'b1;
    m_stop = 1;
    @(negedge clk);
    cfg_stop_gen = 1'b0;
    wait_idle(200);

    // Zero packets: completion drops for one cycle only.
    start_gen(48'h1, 48'h2, 64, 0, 0);
    check("zero_busy", {stat_gen_compl, tx_valid}, 2'b00);
    @(negedge clk);
    check("zero_done", {stat_gen_compl, tx_valid}, 2'b10);
    check("zero_cnt", stat_pkt_cnt, 32'd0);

    // Short length is clamped up to 46.
    start_gen(48'h3, 48'h4, 20, 1, 0);
    check("clamp_len", tx_data[159:144], 16'h002E);
    wait_idle(50);

    // Randomized configurations under backpressure.
    rand_ready = 1;
    for (int t = 0; t < 6; t++) begin
      start_gen({$urandom, 16'($urandom)}, {$urandom, 16'($urandom)},
                int'($urandom_range(0, 2047)), int'($urandom_range(1, 3)),
                1'b0);
      wait_idle(5000);
    end
    rand_ready = 0;
    @(negedge clk);

    // Reset mid-frame truncates with no further beats.
    start_gen(48'h5, 48'h6, 200, 1, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    check("reset_trunc", {tx_valid, stat_gen_compl, stat_pkt_cnt},
          {1'b0, 1'b1, 32'd0});
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_quiet", tx_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
